ins_fetch_ctrl: RTL and testbench

Sequencing controller for the instruction memory (ins_mem: combinational read, word array of MEM_DEPTH entries, byte-addressed pc input).
- Owns ins_mem's pc input.
- Arbitrates ins_mem between a program-loader write port (boot phase) and CPU instruction fetch (run phase).
- Registers fetched instructions into the IF/ID boundary.
- Detects halt and address faults.

---
 rtl/ins_fetch_if.sv | 14 +
 rtl/ins_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_ins_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_if.sv
// Program-loader handshake into the instruction fetch controller.
interface ins_fetch_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_err;

  modport master (output ld_valid, ld_addr, ld_data, ld_done,
                  input  ld_ready, ld_err);
  modport slave  (input  ld_valid, ld_addr, ld_data, ld_done,
                  output ld_ready, ld_err);
endinterface

// File: rtl/ins_fetch_ctrl.sv
// Instruction memory sequencer: boot-time loader writes, then fetch into IF/ID,
// stopping on the halt encoding or on an out-of-range/misaligned pc.
//
// state   | meaning
// S_LOAD  | loader owns ins_mem, pc parked at RESET_PC
// S_RUN   | fetching one instruction per cycle
// S_HALT  | halt instruction fetched, waiting for reload
// S_FAULT | illegal pc presented, waiting for reload
module ins_fetch_ctrl #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INS  = 32'hEF00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  ins_fetch_if.slave  ld,
  output logic        mem_we,
  output logic [5:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        reload,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, if_pc_nxt, if_ins_nxt, fetch_cnt_nxt;
  logic        if_valid_nxt, ld_err_q, ld_err_nxt;
  logic        ld_fire, addr_ok, pc_bad;

  assign ld.ld_ready = (state == S_LOAD);
  assign ld.ld_err   = ld_err_q;
  assign ld_fire     = ld.ld_valid & ld.ld_ready;
  assign addr_ok     = 32'(ld.ld_addr) < DEPTH_U;
  assign mem_we      = ld_fire & addr_ok;
  assign mem_waddr   = ld.ld_addr;
  assign mem_wdata   = ld.ld_data;
  assign halted      = (state == S_HALT);
  assign fault       = (state == S_FAULT);
  assign pc_bad      = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= DEPTH_U);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= 32'h0;
      if_ins    <= 32'h0;
      fetch_cnt <= 32'h0;
      ld_err_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      if_valid  <= if_valid_nxt;
      if_pc     <= if_pc_nxt;
      if_ins    <= if_ins_nxt;
      fetch_cnt <= fetch_cnt_nxt;
      ld_err_q  <= ld_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    if_valid_nxt  = if_valid;
    if_pc_nxt     = if_pc;
    if_ins_nxt    = if_ins;
    fetch_cnt_nxt = fetch_cnt;
    ld_err_nxt    = ld_fire & ~addr_ok;
    unique case (state)
      S_LOAD: begin
        pc_nxt       = RESET_PC;
        if_valid_nxt = 1'b0;
        // a word offered alongside ld_done is still written this cycle
        if (ld.ld_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (br_taken) begin
          pc_nxt       = br_target;
          if_valid_nxt = 1'b0;
        end else if (pc_bad) begin
          state_nxt    = S_FAULT;
          if_valid_nxt = 1'b0;
        end else if (!stall) begin
          if_valid_nxt  = 1'b1;
          if_pc_nxt     = pc;
          if_ins_nxt    = ins;
          fetch_cnt_nxt = fetch_cnt + 32'd1;
          if (ins == HALT_INS) state_nxt = S_HALT;
          else                 pc_nxt    = pc + 32'd4;
        end
      end
      S_HALT, S_FAULT: begin
        if_valid_nxt = 1'b0;
        if (reload) begin
          state_nxt = S_LOAD;
          pc_nxt    = RESET_PC;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl: loader boot, fetch/stall/branch/fault/halt
// sequencing, plus a shallow-memory instance to reach out-of-range loader writes.
module tb_ins_fetch_ctrl;

  localparam logic [31:0] I0 = 32'hE3A0_0001;
  localparam logic [31:0] I1 = 32'hE3A0_1002;
  localparam logic [31:0] I2 = 32'hE080_2001;
  localparam logic [31:0] HT = 32'hEF00_0000;
  localparam logic [31:0] I4 = 32'hE3A0_3004;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ins_fetch_if ldi ();
  ins_fetch_if lds ();

  logic        mem_we, halted, fault, if_valid;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata, pc, ins, if_pc, if_ins, fetch_cnt;
  logic        stall, br_taken, reload;
  logic [31:0] br_target;

  logic        s_mem_we, s_halted, s_fault, s_if_valid;
  logic [5:0]  s_mem_waddr;
  logic [31:0] s_mem_wdata, s_pc, s_if_pc, s_if_ins, s_fetch_cnt;

  ins_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ld(ldi.slave),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .pc(pc), .ins(ins), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .reload(reload), .if_valid(if_valid),
    .if_pc(if_pc), .if_ins(if_ins), .halted(halted), .fault(fault),
    .fetch_cnt(fetch_cnt)
  );

  ins_fetch_ctrl #(.MEM_DEPTH(32)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .ld(lds.slave),
    .mem_we(s_mem_we), .mem_waddr(s_mem_waddr), .mem_wdata(s_mem_wdata),
    .pc(s_pc), .ins(32'h0), .stall(1'b0), .br_taken(1'b0),
    .br_target(32'h0), .reload(1'b0), .if_valid(s_if_valid),
    .if_pc(s_if_pc), .if_ins(s_if_ins), .halted(s_halted), .fault(s_fault),
    .fetch_cnt(s_fetch_cnt)
  );

  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end
  assign ins = (pc < 32'd256) ? mem[pc[7:2]] : 32'h0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d, input logic done);
    ldi.ld_valid = 1'b1;
    ldi.ld_addr  = a;
    ldi.ld_data  = d;
    ldi.ld_done  = done;
    tick();
    ldi.ld_valid = 1'b0;
    ldi.ld_done  = 1'b0;
  endtask

  typedef struct {
    logic        ld_done, stall, br, reload;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ifpc, e_ins;
    logic        e_halt, e_fault, e_rdy;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  initial begin
    // ld_done stall br reload tgt | pc v if_pc if_ins halt fault ready cnt
    vq.push_back('{0,0,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,1});
    vq.push_back('{0,0,0,0,32'h0 , 32'h8  ,1,32'h4 ,I1,0,0,0,2});
    vq.push_back('{0,0,0,0,32'h0 , 32'hC  ,1,32'h8 ,I2,0,0,0,3});
    vq.push_back('{0,0,0,0,32'h0 , 32'hC  ,1,32'hC ,HT,1,0,0,4});
    vq.push_back('{0,0,0,0,32'h0 , 32'hC  ,0,32'hC ,HT,1,0,0,4});
    vq.push_back('{0,1,1,0,32'h0 , 32'hC  ,0,32'hC ,HT,1,0,0,4});
    vq.push_back('{0,0,0,1,32'h0 , 32'h0  ,0,32'hC ,HT,0,0,1,4});
    vq.push_back('{1,0,0,0,32'h0 , 32'h0  ,0,32'hC ,HT,0,0,0,4});
    vq.push_back('{0,0,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,5});
    vq.push_back('{0,1,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,5});
    vq.push_back('{0,1,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,5});
    vq.push_back('{0,1,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,5});
    vq.push_back('{0,0,0,0,32'h0 , 32'h8  ,1,32'h4 ,I1,0,0,0,6});
    vq.push_back('{0,1,1,0,32'h10, 32'h10 ,0,32'h4 ,I1,0,0,0,6});
    vq.push_back('{0,0,0,0,32'h0 , 32'h14 ,1,32'h10,I4,0,0,0,7});
    vq.push_back('{0,0,1,0,32'h19, 32'h19 ,0,32'h10,I4,0,0,0,7});
    vq.push_back('{0,0,0,0,32'h0 , 32'h19 ,0,32'h10,I4,0,1,0,7});
    vq.push_back('{0,1,1,0,32'h0 , 32'h19 ,0,32'h10,I4,0,1,0,7});
    vq.push_back('{0,0,0,1,32'h0 , 32'h0  ,0,32'h10,I4,0,0,1,7});
    vq.push_back('{0,1,1,1,32'h44, 32'h0  ,0,32'h10,I4,0,0,1,7});
    vq.push_back('{1,0,0,0,32'h0 , 32'h0  ,0,32'h10,I4,0,0,0,7});
    vq.push_back('{0,0,0,0,32'h0 , 32'h4  ,1,32'h0 ,I0,0,0,0,8});
    vq.push_back('{0,0,1,0,32'h100,32'h100,0,32'h0 ,I0,0,0,0,8});
    vq.push_back('{0,0,0,0,32'h0 , 32'h100,0,32'h0 ,I0,0,1,0,8});
    vq.push_back('{0,0,0,1,32'h0 , 32'h0  ,0,32'h0 ,I0,0,0,1,8});

    ldi.ld_valid = 0; ldi.ld_addr = '0; ldi.ld_data = '0; ldi.ld_done = 0;
    lds.ld_valid = 0; lds.ld_addr = '0; lds.ld_data = '0; lds.ld_done = 0;
    stall = 0; br_taken = 0; br_target = '0; reload = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_ld_ready", 32'(ldi.ld_ready), 32'h1);
    chk("rst_ld_err", 32'(ldi.ld_err), 32'h0);
    rst_n = 1'b1;

    load_word(6'd4, I4, 1'b0);
    load_word(6'd5, HT, 1'b0);
    load_word(6'd0, I0, 1'b0);
    load_word(6'd1, I1, 1'b0);
    load_word(6'd2, I2, 1'b0);
    ldi.ld_valid = 1'b1; ldi.ld_addr = 6'd3; ldi.ld_data = HT;
    #1;
    chk("load_mem_we", 32'(mem_we), 32'h1);
    tick();
    ldi.ld_valid = 1'b0;
    chk("load_still_ready", 32'(ldi.ld_ready), 32'h1);
    ldi.ld_done = 1'b1;
    tick();
    ldi.ld_done = 1'b0;
    chk("run_ld_ready", 32'(ldi.ld_ready), 32'h0);
    chk("run_pc0", pc, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      ldi.ld_done = vq[i].ld_done;
      stall       = vq[i].stall;
      br_taken    = vq[i].br;
      br_target   = vq[i].tgt;
      reload      = vq[i].reload;
      tick();
      chk($sformatf("row%0d_pc", i), pc, vq[i].e_pc);
      chk($sformatf("row%0d_if_valid", i), 32'(if_valid), 32'(vq[i].e_v));
      chk($sformatf("row%0d_if_pc", i), if_pc, vq[i].e_ifpc);
      chk($sformatf("row%0d_if_ins", i), if_ins, vq[i].e_ins);
      chk($sformatf("row%0d_halted", i), 32'(halted), 32'(vq[i].e_halt));
      chk($sformatf("row%0d_fault", i), 32'(fault), 32'(vq[i].e_fault));
      chk($sformatf("row%0d_ld_ready", i), 32'(ldi.ld_ready), 32'(vq[i].e_rdy));
      chk($sformatf("row%0d_cnt", i), fetch_cnt, vq[i].e_cnt);
    end
    ldi.ld_done = 0; stall = 0; br_taken = 0; br_target = '0; reload = 0;

    // word offered in the same cycle as ld_done: written, then RUN
    ldi.ld_valid = 1'b1; ldi.ld_addr = 6'd0; ldi.ld_data = HT; ldi.ld_done = 1'b1;
    #1;
    chk("done_wr_mem_we", 32'(mem_we), 32'h1);
    tick();
    ldi.ld_valid = 1'b0; ldi.ld_done = 1'b0;
    chk("done_wr_ready", 32'(ldi.ld_ready), 32'h0);
    chk("done_wr_mem0", mem[0], HT);
    tick();
    chk("done_wr_halted", 32'(halted), 32'h1);
    chk("done_wr_if_ins", if_ins, HT);
    chk("done_wr_if_pc", if_pc, 32'h0);
    chk("done_wr_cnt", fetch_cnt, 32'd9);

    // back to RUN at pc=8, then a one-cycle synchronous reset
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_word(6'd0, I0, 1'b1);
    tick();
    tick();
    chk("pre_rst_pc", pc, 32'h8);
    chk("pre_rst_cnt", fetch_cnt, 32'd11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_if_valid", 32'(if_valid), 32'h0);
    chk("mid_rst_cnt", fetch_cnt, 32'h0);
    chk("mid_rst_ready", 32'(ldi.ld_ready), 32'h1);
    chk("mid_rst_if_pc", if_pc, 32'h0);
    chk("mid_rst_if_ins", if_ins, 32'h0);

    // shallow instance: index 40 is beyond 32 words
    lds.ld_valid = 1'b1; lds.ld_addr = 6'd40; lds.ld_data = 32'hDEAD_BEEF;
    #1;
    chk("oor_mem_we", 32'(s_mem_we), 32'h0);
    chk("oor_err_before", 32'(lds.ld_err), 32'h0);
    tick();
    chk("oor_err_pulse", 32'(lds.ld_err), 32'h1);
    lds.ld_addr = 6'd31;
    #1;
    chk("edge_mem_we", 32'(s_mem_we), 32'h1);
    tick();
    chk("edge_err", 32'(lds.ld_err), 32'h0);
    lds.ld_valid = 1'b0;
    tick();
    chk("idle_err", 32'(lds.ld_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
